hamming74_enc_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one (7,4) Hamming encoder among NREQ byte-wide requesters. Each granted byte is split into two nibbles, low first. The block emits two registered 7-bit codewords on a valid/ready output stream, tagged with the requester ID and a last flag. It sits between the byte producers and the codeword transmit path.

---
 rtl/hamming74_enc_arbiter.sv | 149 ++++++++++++++
 tb/tb_hamming74_enc_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming74_enc_arbiter.sv
// hamming74_enc_arbiter
//   Round-robin arbiter in front of one shared (7,4) Hamming encoder.
//   A granted byte is sent as two codewords: the low nibble first, then
//   the high nibble. Each codeword is tagged with the requester ID and a
//   last flag, and is held stable until the downstream handshake.
//
// Ports
//   clk        clock; all state updates on the rising edge
//   rst        synchronous active-high reset
//   req_valid  [NREQ]    requester i offers a byte
//   req_data   [8*NREQ]  requester i byte at [8i+7:8i]
//   req_ready  [NREQ]    one-hot: requester i's byte is captured this cycle
//   cw_valid   codeword valid
//   cw_ready   downstream accepts the codeword when high together with cw_valid
//   cw_data    [6:0] = {d3,d2,d1,p3,d0,p2,p1}
//   cw_id      [ID_W]    requester index of the current codeword
//   cw_last    0 = low-nibble codeword, 1 = high-nibble codeword
//   busy       high whenever the FSM is not IDLE
module hamming74_enc_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              cw_valid,
  input  logic              cw_ready,
  output logic [6:0]        cw_data,
  output logic [ID_W-1:0]   cw_id,
  output logic              cw_last,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, LO, HI} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [7:0]      hold_q, hold_d;
  logic            cw_valid_q, cw_valid_d;
  logic [6:0]      cw_data_q, cw_data_d;
  logic [ID_W-1:0] cw_id_q, cw_id_d;
  logic            cw_last_q, cw_last_d;

  logic            gnt_found;
  logic [ID_W-1:0] gnt_idx;
  logic [7:0]      gnt_byte;
  logic            cw_hs;

  // Shared (7,4) encoder: parity bits sit at the power-of-two positions.
  function automatic logic [6:0] enc(input logic [3:0] d);
    logic p1, p2, p3;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p3 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p3, d[0], p2, p1};
  endfunction

  // Round-robin scan starting at ptr, wrapping at NREQ-1 (NREQ need not
  // be a power of two, so the wrap is explicit rather than modular).
  always_comb begin
    int              idx;
    logic [ID_W-1:0] cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = ID_W'(idx);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign gnt_byte  = req_data[8*gnt_idx +: 8];
  assign req_ready = (state_q == IDLE && !rst && gnt_found) ?
                     (NREQ'(1) << gnt_idx) : '0;
  assign cw_hs     = cw_valid_q & cw_ready;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_d     = hold_q;
    cw_valid_d = cw_valid_q;
    cw_data_d  = cw_data_q;
    cw_id_d    = cw_id_q;
    cw_last_d  = cw_last_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_found) begin
          hold_d     = gnt_byte;
          cw_id_d    = gnt_idx;
          cw_data_d  = enc(gnt_byte[3:0]);
          cw_last_d  = 1'b0;
          cw_valid_d = 1'b1;
          ptr_d      = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
          state_d    = LO;
        end
      end
      LO: begin
        if (cw_hs) begin
          cw_data_d = enc(hold_q[7:4]);
          cw_last_d = 1'b1;
          state_d   = HI;
        end
      end
      HI: begin
        // No new grant here: the following IDLE cycle is always taken.
        if (cw_hs) begin
          cw_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      hold_q     <= '0;
      cw_valid_q <= 1'b0;
      cw_data_q  <= '0;
      cw_id_q    <= '0;
      cw_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_q     <= hold_d;
      cw_valid_q <= cw_valid_d;
      cw_data_q  <= cw_data_d;
      cw_id_q    <= cw_id_d;
      cw_last_q  <= cw_last_d;
    end
  end

  assign cw_valid = cw_valid_q;
  assign cw_data  = cw_data_q;
  assign cw_id    = cw_id_q;
  assign cw_last  = cw_last_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_hamming74_enc_arbiter.sv
module tb_hamming74_enc_arbiter;
  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              cw_valid;
  logic              cw_ready;
  logic [6:0]        cw_data;
  logic [ID_W-1:0]   cw_id;
  logic              cw_last;
  logic              busy;

  hamming74_enc_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cw_valid  (cw_valid),
    .cw_ready  (cw_ready),
    .cw_data   (cw_data),
    .cw_id     (cw_id),
    .cw_last   (cw_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus state (requester side)
  logic [NREQ-1:0] rv;
  logic [7:0]      rd [NREQ];
  logic            crdy;
  logic            rst_v;
  bit              reoffer;

  // Observed outputs of the last step
  logic [NREQ-1:0] obs_rdy;
  logic            obs_valid, obs_last, obs_busy;
  logic [6:0]      obs_data;
  logic [ID_W-1:0] obs_id;

  // Reference model: queue of codewords still owed downstream
  typedef struct {
    logic [6:0] cw;
    int         id;
    bit         last;
  } cw_t;
  cw_t mq[$];
  int  m_ptr;
  int  grants[$];

  int n_chk;
  int n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Classic Hamming construction: data at positions 3,5,6,7; parity at
  // position 2^k is the XOR of every position whose index has bit k set.
  function automatic logic [6:0] ref_enc(input logic [3:0] n);
    logic [7:1] pos;
    int dpos [4];
    dpos[0] = 3; dpos[1] = 5; dpos[2] = 6; dpos[3] = 7;
    pos = '0;
    for (int i = 0; i < 4; i++) pos[dpos[i]] = n[i];
    for (int k = 0; k < 3; k++) begin
      logic p;
      p = 1'b0;
      for (int j = 1; j <= 7; j++)
        if (((j >> k) & 1) == 1 && j != (1 << k)) p = p ^ pos[j];
      pos[1 << k] = p;
    end
    return pos[7:1];
  endfunction

  task automatic step();
    int g;
    logic [NREQ-1:0] er;
    cw_t e;
    @(negedge clk);
    rst       = rst_v;
    req_valid = rv;
    cw_ready  = crdy;
    for (int i = 0; i < NREQ; i++) req_data[8*i +: 8] = rd[i];
    #1;
    obs_rdy   = req_ready;
    obs_valid = cw_valid;
    obs_data  = cw_data;
    obs_id    = cw_id;
    obs_last  = cw_last;
    obs_busy  = busy;

    g = -1;
    if (!rst_v && mq.size() == 0)
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && rv[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
    er = '0;
    if (g >= 0) er[g] = 1'b1;

    chk("req_ready", 32'(obs_rdy), 32'(er));
    chk("cw_valid", 32'(obs_valid), 32'(mq.size() != 0));
    chk("busy", 32'(obs_busy), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("cw_data", 32'(obs_data), 32'(mq[0].cw));
      chk("cw_id", 32'(obs_id), 32'(mq[0].id));
      chk("cw_last", 32'(obs_last), 32'(mq[0].last));
    end

    if (rst_v) begin
      mq.delete();
      m_ptr = 0;
    end else if (g >= 0) begin
      e.cw = ref_enc(rd[g][3:0]); e.id = g; e.last = 1'b0; mq.push_back(e);
      e.cw = ref_enc(rd[g][7:4]); e.id = g; e.last = 1'b1; mq.push_back(e);
      m_ptr = (g + 1) % NREQ;
      grants.push_back(g);
      if (reoffer) rd[g] = 8'($urandom);
      else rv[g] = 1'b0;
    end else if (mq.size() != 0 && crdy) begin
      void'(mq.pop_front());
    end
  endtask

  task automatic do_reset();
    rst_v = 1'b1;
    rv    = '0;
    step();
    rst_v = 1'b0;
    grants.delete();
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rv = '0; crdy = 1'b1; rst_v = 1'b0; reoffer = 1'b0;
    for (int i = 0; i < NREQ; i++) rd[i] = '0;
    rst = 1'b1; req_valid = '0; req_data = '0; cw_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_cw_valid", 32'(cw_valid), 32'd0);
    chk("rst_cw_data", 32'(cw_data), 32'd0);
    chk("rst_cw_id", 32'(cw_id), 32'd0);
    chk("rst_cw_last", 32'(cw_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    mq.delete(); m_ptr = 0;

    // Single requester 1, byte 0xB1
    do_reset();
    rv = 4'b0010; rd[1] = 8'hB1; crdy = 1'b1;
    step(); chk("tp1_ready", 32'(obs_rdy), 32'b0010);
    step(); chk("tp1_lo", 32'(obs_data), 32'h07);
    chk("tp1_lo_id", 32'(obs_id), 32'd1); chk("tp1_lo_last", 32'(obs_last), 32'd0);
    step(); chk("tp1_hi", 32'(obs_data), 32'h55); chk("tp1_hi_last", 32'(obs_last), 32'd1);
    step(); chk("tp1_done_valid", 32'(obs_valid), 32'd0); chk("tp1_done_busy", 32'(obs_busy), 32'd0);

    // All four continuously valid: 0,1,2,3,0 every 3 cycles
    do_reset();
    reoffer = 1'b1; rv = 4'b1111;
    for (int i = 0; i < NREQ; i++) rd[i] = 8'($urandom);
    repeat (15) step();
    chk("rr4_count", 32'(grants.size()), 32'd5);
    for (int i = 0; i < 5 && i < grants.size(); i++)
      chk("rr4_order", 32'(grants[i]), 32'(i % NREQ));

    // Requesters 0 and 2 continuously valid
    do_reset();
    rv = 4'b0101;
    repeat (12) step();
    chk("rr02_count", 32'(grants.size()), 32'd4);
    for (int i = 0; i < grants.size(); i++)
      chk("rr02_order", 32'(grants[i]), 32'((i % 2) * 2));
    reoffer = 1'b0;

    // Backpressure in LO with byte 0xA2; others waiting
    do_reset();
    rv = 4'b0111; rd[0] = 8'hA2; rd[1] = 8'h5E; rd[2] = 8'hC3; crdy = 1'b0;
    step(); chk("bp_accept", 32'(obs_rdy), 32'b0001);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_data", 32'(obs_data), 32'h19);
      chk("bp_hold_valid", 32'(obs_valid), 32'd1);
      chk("bp_no_ready", 32'(obs_rdy), 32'd0);
    end
    crdy = 1'b1;
    step(); chk("bp_lo_hs", 32'(obs_data), 32'h19);
    step(); chk("bp_hi", 32'(obs_data), 32'h52); chk("bp_hi_last", 32'(obs_last), 32'd1);
    repeat (8) step();

    // Requester 3: 0xFF then 0x00
    do_reset();
    rv = 4'b1000; rd[3] = 8'hFF;
    step();
    step(); chk("r3_ff_lo", 32'(obs_data), 32'h7F); chk("r3_ff_lo_id", 32'(obs_id), 32'd3);
    step(); chk("r3_ff_hi", 32'(obs_data), 32'h7F); chk("r3_ff_hi_id", 32'(obs_id), 32'd3);
    rv = 4'b1000; rd[3] = 8'h00;
    step(); chk("r3_00_accept", 32'(obs_rdy), 32'b1000);
    step(); chk("r3_00_lo", 32'(obs_data), 32'h00); chk("r3_00_lo_id", 32'(obs_id), 32'd3);
    step(); chk("r3_00_hi", 32'(obs_data), 32'h00); chk("r3_00_hi_last", 32'(obs_last), 32'd1);

    // Reset while in HI with cw_ready low
    do_reset();
    rv = 4'b0010; rd[1] = 8'h3C; crdy = 1'b1;
    step(); step();
    crdy = 1'b0;
    step(); chk("mr_in_hi", 32'(obs_last), 32'd1);
    rst_v = 1'b1; step(); rst_v = 1'b0;
    rv = 4'b1001; rd[0] = 8'h11; rd[3] = 8'h99; crdy = 1'b1;
    step();
    chk("mr_valid", 32'(obs_valid), 32'd0);
    chk("mr_busy", 32'(obs_busy), 32'd0);
    chk("mr_ptr0_wins", 32'(obs_rdy), 32'b0001);
    step(); step();
    step(); chk("mr_r3_alone", 32'(obs_rdy), 32'b1000);
    repeat (3) step();

    // Randomized traffic with occasional resets
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (!rv[i] && $urandom_range(0, 9) < 3) begin
          rv[i] = 1'b1;
          rd[i] = 8'($urandom);
        end
      crdy  = ($urandom_range(0, 9) < 7);
      rst_v = ($urandom_range(0, 199) == 0);
      step();
    end
    rst_v = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
